product_seg_encoder: RTL
========================

Name: product_seg_encoder

Overview:
- Downstream stage of the signed Booth multiplier. It takes the multiplier's 15-bit two's-complement product and converts it sequentially to sign plus decimal digits.
- Conversion is double-dabble, one bit per cycle. Digits are emitted in the same 7-segment code the multiplier's operand decoder accepts, so results round-trip to the display/operand format.
- A start/busy/done handshake decouples it from the combinational multiplier.

Parameters:
- IN_W, 15, width of the signed product input.
- DIGITS, 4, number of displayed decimal digits.
- BLANK, 1, 1 = blank leading zeros (units digit never blanked); 0 = show leading zeros.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion of product; sampled only in IDLE
- product  input  IN_W  signed two's-complement value; captured on the accepting edge
- busy  output  1  high from the accepting edge until the done cycle
- done  output  1  one-cycle pulse when outputs are updated
- neg  output  1  sign of the last converted value (1 = negative)
- ovf  output  1  magnitude exceeded 10^DIGITS-1
- seg_out  output  7*DIGITS  digit codes {a,b,c,d,e,f,g}, active-high; digit DIGITS-1 is MSD at the top bits

Behaviour:
- Segment codes:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - blank=0000000, minus=0000001
- Reset (synchronous, overrides everything, including mid-conversion): state IDLE, busy=0, done=0, neg=0, ovf=0.
  - seg_out resets to the encoding of 0: with BLANK=1, blanks plus 1111110 in the units digit; with BLANK=0, all digits 1111110.
  - An aborted conversion produces no done pulse.
- States: IDLE, CONV, ENC.
- IDLE:
  - start=1 → capture neg=product[IN_W-1] and mag=|product| (IN_W-bit unsigned, so -2^(IN_W-1) is representable).
  - Clear the BCD register, which holds 4*(DIGITS+1) bits (one guard digit).
  - Set cnt=IN_W, busy=1, go to CONV.
- CONV:
  - Each edge: every BCD nibble ≥5 gets +3, then {bcd,mag} shifts left 1 and cnt decrements.
  - When cnt reaches 0 on this edge, go to ENC.
  - Exactly IN_W shift edges.
- ENC: one edge that registers seg_out, neg, and ovf, pulses done=1, clears busy, and returns to IDLE.
- Latency: start sampled at edge E0 → done and new outputs visible after edge E(IN_W+1), i.e. 16 edges at default.
- Overflow: if the guard digit ≠ 0 then ovf=1 and every digit = minus; otherwise ovf=0.
- Blanking: with BLANK=1, a digit is blank if it and all higher digits are zero, except the units digit.
- neg is reported as captured; -0 cannot occur. neg is independent of seg_out, so the caller displays the sign.
- Outputs hold their values between done pulses; product may change freely while busy.
- start while busy (CONV/ENC) is ignored with no queueing.
- start in the cycle after done (state IDLE) is accepted, allowing back-to-back conversions every IN_W+1 edges.

Decomposition:
- Shared package/header holds SEG_0..SEG_9, SEG_BLANK, SEG_MINUS, and the state encodings (IDLE/CONV/ENC). The operand decoder should reuse the same constants.
- One combinational sub-module, bcd_to_seg: 4-bit BCD → 7-bit code, instantiated DIGITS times.
- Add-3/shift, blanking, and overflow muxing stay in product_seg_encoder.

Test Plan:
- reset, then product=0, start pulse → after 16 edges done=1 for one cycle; seg_out = blank,blank,blank,1111110; neg=0; ovf=0.
- product=+1234 (15'h04D2) → seg_out = 0110000,1101101,1111001,0110011; neg=0; ovf=0. Repeat with +12 → blank,blank,0110000,1101101.
- product=-9801 (15'h59B7) → seg_out = 1111011,1111111,1111110,0110000; neg=1; ovf=0.
- product=-16384 (15'h4000) → ovf=1; seg_out all 0000001; neg=1. Then +10000 → ovf=1, neg=0.
- start held high and product changed during busy → only one done pulse, and the result reflects the value captured at E0. start in the cycle after done → second conversion completes 16 edges later.
- reset asserted after 5 CONV edges → next edge busy=0 and outputs at reset values; no done pulse ever appears for the aborted conversion.

Source files
------------

// File: rtl/product_seg_encoder_pkg.sv
// -----------------------------------------------------------------------------
// product_seg_encoder_pkg
//
// Shared constants for the product display path. The 7-segment codes here are
// the same ones the multiplier's operand decoder accepts, so a displayed result
// can be fed straight back in as an operand.
//
// Contents:
//   SEG_0 .. SEG_9   digit codes {a,b,c,d,e,f,g}, active-high
//   SEG_BLANK        all segments off (suppressed leading zero)
//   SEG_MINUS        segment g only (overflow indication)
//   state_t          encoder FSM states (IDLE / CONV / ENC)
//   add3()           double-dabble digit correction
// -----------------------------------------------------------------------------
package product_seg_encoder_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_ENC  = 2'd2
    } state_t;

    // A BCD digit of 5 or more would exceed 9 after the next left shift;
    // adding 3 first makes the shift carry into the next digit instead.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/product_seg_encoder_bcd_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seg
//
// Combinational BCD digit to 7-segment code.
//
// Ports:
//   bcd  in   4  BCD digit 0..9
//   seg  out  7  code {a,b,c,d,e,f,g}, active-high; non-BCD inputs give blank
// -----------------------------------------------------------------------------
module bcd_to_seg
    import product_seg_encoder_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: the default arm assigns seg on every path, so no latch is
        // inferred; it also covers the six codes double-dabble never produces.
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/product_seg_encoder.sv
// -----------------------------------------------------------------------------
// product_seg_encoder
//
// Converts the signed Booth multiplier product to sign + decimal 7-segment
// digits using double-dabble, one product bit per clock.
//
// Timing: start sampled in IDLE at edge E0, IN_W shift edges in CONV, one ENC
// edge registers the result, so done and the new outputs appear after E(IN_W+1).
//
// Parameters:
//   IN_W    width of the signed product
//   DIGITS  number of displayed decimal digits
//   BLANK   1 = suppress leading zeros (units digit always shown)
//
// Ports:
//   clk      in   1         rising-edge clock
//   reset    in   1         synchronous active-high reset, aborts a conversion
//   start    in   1         conversion request, only honoured in IDLE
//   product  in   IN_W      two's-complement value, captured on accept
//   busy     out  1         accept edge until the done cycle
//   done     out  1         one-cycle pulse, outputs updated
//   neg      out  1         sign of the last converted value
//   ovf      out  1         magnitude above 10^DIGITS-1 (all digits show minus)
//   seg_out  out  7*DIGITS  digit codes, digit DIGITS-1 in the top bits
// -----------------------------------------------------------------------------
module product_seg_encoder
    import product_seg_encoder_pkg::*;
#(
    parameter int IN_W   = 15,
    parameter int DIGITS = 4,
    parameter int BLANK  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_W-1:0]       product,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   seg_out
);

    // One guard digit above the displayed ones detects overflow.
    localparam int BCD_W = 4 * (DIGITS + 1);
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [IN_W-1:0]  MAG_ONE = IN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Display of the value 0, used as the reset image of seg_out.
    function automatic logic [7*DIGITS-1:0] zero_image();
        logic [7*DIGITS-1:0] img;
        for (int i = 0; i < DIGITS; i++) begin
            img[7*i +: 7] = (BLANK != 0 && i != 0) ? SEG_BLANK : SEG_0;
        end
        return img;
    endfunction

    localparam logic [7*DIGITS-1:0] SEG_RESET = zero_image();

    state_t                   state;
    logic [IN_W-1:0]          mag;
    logic [BCD_W-1:0]         bcd;
    logic [CNT_W-1:0]         cnt;
    logic                     neg_cap;

    logic [BCD_W-1:0]         bcd_adj;
    logic [BCD_W+IN_W-1:0]    shift_next;
    logic [6:0]               dig_seg [DIGITS];
    logic [7*DIGITS-1:0]      seg_next;
    logic                     ovf_next;

    // Add-3 correction on every nibble, then shift {bcd, mag} left by one.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS + 1; i++) begin
            bcd_adj[4*i +: 4] = add3(bcd[4*i +: 4]);
        end
        shift_next = {bcd_adj, mag} << 1;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_to_seg u_bcd_to_seg (
            .bcd (bcd[4*g +: 4]),
            .seg (dig_seg[g])
        );
    end

    // Final display image from the completed BCD value. Leading-zero tracking
    // walks from the MSD down; the units digit is never blanked so 0 shows as 0.
    always_comb begin
        logic lead_zero;
        ovf_next  = (bcd[BCD_W-1 -: 4] != 4'd0);
        seg_next  = '0;
        lead_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (bcd[4*i +: 4] == 4'd0);
            if (ovf_next) begin
                seg_next[7*i +: 7] = SEG_MINUS;
            end else if (BLANK != 0 && i != 0 && lead_zero) begin
                seg_next[7*i +: 7] = SEG_BLANK;
            end else begin
                seg_next[7*i +: 7] = dig_seg[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignment so every register
        // updates from the pre-edge values, independent of statement order.
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
            seg_out <= SEG_RESET;
            mag     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            neg_cap <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Magnitude kept at IN_W unsigned bits so the most
                        // negative product still has a representable magnitude.
                        neg_cap <= product[IN_W-1];
                        mag     <= product[IN_W-1] ? (~product + MAG_ONE) : product;
                        bcd     <= '0;
                        cnt     <= CNT_W'(IN_W);
                        busy    <= 1'b1;
                        state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd <= shift_next[BCD_W+IN_W-1 -: BCD_W];
                    mag <= shift_next[IN_W-1:0];
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    seg_out <= seg_next;
                    neg     <= neg_cap;
                    ovf     <= ovf_next;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
